branch_pc_sequencer: RTL
========================

// Module: branch_pc_sequencer
// PURPOSE
//   Sequences conditional branches (brzr/brnz/brpl/brmi) and owns the PC register.
//   Sits directly downstream of the CON FF and drives its CONin strobe.
//   Consumes the FF's BranchOut result and applies PC <= PC + sext(C2) when taken.
//   Also serves normal PC increment/load for the control unit; keeps saturating taken/not-taken counts.
// PARAMETERS
//   PC_W     32  PC and Bus width
//   DISP_W   19  branch displacement width (IR[DISP_W-1:0], two's complement)
//   CNT_W    16  width of taken/not-taken statistics counters
//   SETTLE   1   cycles waited after CONin strobe before sampling BranchIn (>=1)
// PORTS
//   clk        in   1      single clock, rising edge
//   reset_n    in   1      asynchronous, active-low reset
//   start      in   1      control unit: branch instruction in execute, 1-cycle pulse
//   IR         in   PC_W   instruction register; C2 = IR[DISP_W-1:0]
//   Bus        in   PC_W   datapath bus, source for PCload
//   IncPC      in   1      PC <= PC + 1 (fetch)
//   PCload     in   1      PC <= Bus (jr/jal/reset vector)
//   BranchIn   in   1      BranchOut from CON FF
//   CONin      out  1      registered strobe to CON FF (its rising edge captures)
//   PC         out  PC_W   current program counter
//   busy       out  1      FSM not in IDLE
//   done       out  1      1-cycle pulse, branch resolved
//   taken      out  1      valid with done: 1 = branch applied
//   taken_cnt  out  CNT_W  saturating count of taken branches
//   nt_cnt     out  CNT_W  saturating count of not-taken branches
// BEHAVIOUR
//   Reset (reset_n=0, async): PC=0, state=IDLE, CONin=0, done=0, taken=0, counters=0.
//   States: IDLE -> STROBE -> SETTLE -> RESOLVE -> IDLE.
//   IDLE: start=1 latches disp = sext(IR[DISP_W-1:0]) to PC_W bits; next STROBE.
//   STROBE: CONin=1 for exactly one cycle (registered, glitch-free); next SETTLE.
//   SETTLE: CONin=0; stays SETTLE cycles, then RESOLVE.
//   RESOLVE: sample BranchIn; if 1: PC <= PC + disp, taken=1; else PC unchanged, taken=0.
//     done=1 this cycle only; increments taken_cnt or nt_cnt; next IDLE.
//   Latency: start at edge N -> CONin high N+1 -> done at N+2+SETTLE (N+3 default).
//   start while busy: ignored, no queueing.
//   PC arithmetic modulo 2^PC_W; negative disp wraps (PC=0, disp=-1 -> 0xFFFFFFFF).
//   PC update priority in one cycle: PCload > RESOLVE-taken > IncPC.
//     IncPC in RESOLVE with taken=0: PC <= PC + 1 (still applies).
//     IncPC in RESOLVE with taken=1: increment dropped.
//   PCload while busy: PC <= Bus; FSM aborts to IDLE; no done, no counter change; CONin forced 0.
//   IncPC and PCload in any other state act normally; FSM unaffected by IncPC.
//   Counters saturate at 2^CNT_W-1; no wrap.
//   Reset mid-operation: immediate return to IDLE with all reset values; CONin drops asynchronously.
//   done and taken are registered outputs; taken holds its value until next done.
// TESTING
//   1 Reset: assert reset_n=0 mid-STROBE -> CONin=0, PC=0, busy=0, counters 0 immediately.
//   2 Taken: PC=0x100, IR[18:0]=0x00010, start; BranchIn=1 -> CONin pulse at N+1,
//     done at N+3, PC=0x110, taken=1, taken_cnt=1.
//   3 Not taken: same setup, BranchIn=0 -> done at N+3, PC=0x100, taken=0, nt_cnt=1.
//   4 Negative wrap: PC=0x0, IR[18:0]=0x7FFFF, BranchIn=1 -> PC=0xFFFFFFFF.
//   5 Collisions: IncPC in RESOLVE with taken=1 -> PC=PC+disp only.
//     PCload Bus=0x40 during SETTLE -> PC=0x40, no done, busy=0 next cycle.
//   6 Saturation/ignore: CNT_W=2, 5 taken branches -> taken_cnt=3; start during busy -> ignored, one done only.

Source files
------------

// File: rtl/branch_pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// branch_pc_sequencer_if
//   Bundles the control-unit, CON FF and status signals of the branch/PC
//   sequencer so they travel as one port.
//
//   master : environment side (control unit + CON FF). Drives start, IR, Bus,
//            IncPC, PCload and BranchIn; observes everything else.
//   slave  : the sequencer itself.
//
//   start      control unit: branch instruction in execute, 1-cycle pulse
//   IR         instruction register, displacement in IR[DISP_W-1:0]
//   Bus        datapath bus, source for PCload
//   IncPC      PC <= PC + 1
//   PCload     PC <= Bus
//   BranchIn   BranchOut result from the CON FF
//   CONin      registered capture strobe to the CON FF
//   PC         current program counter
//   busy       sequencer not idle
//   done       1-cycle pulse, branch resolved
//   taken      valid with done, holds until the next done
//   taken_cnt  saturating count of taken branches
//   nt_cnt     saturating count of not-taken branches
// ---------------------------------------------------------------------------
interface branch_pc_sequencer_if #(
    parameter int PC_W   = 32,
    parameter int DISP_W = 19,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [PC_W-1:0]   IR;
    logic [PC_W-1:0]   Bus;
    logic              IncPC;
    logic              PCload;
    logic              BranchIn;
    logic              CONin;
    logic [PC_W-1:0]   PC;
    logic              busy;
    logic              done;
    logic              taken;
    logic [CNT_W-1:0]  taken_cnt;
    logic [CNT_W-1:0]  nt_cnt;

    modport master (
        output start, IR, Bus, IncPC, PCload, BranchIn,
        input  CONin, PC, busy, done, taken, taken_cnt, nt_cnt
    );

    modport slave (
        input  start, IR, Bus, IncPC, PCload, BranchIn,
        output CONin, PC, busy, done, taken, taken_cnt, nt_cnt
    );
endinterface

// File: rtl/branch_pc_sequencer.sv
// ---------------------------------------------------------------------------
// branch_pc_sequencer
//   Owns the program counter and sequences conditional branches through the
//   CON FF: strobes CONin, waits for BranchOut to settle, then applies
//   PC <= PC + sext(C2) when the condition holds. Also services plain PC
//   increment and PC load for the control unit, and keeps saturating
//   taken / not-taken statistics.
//
//   Ports
//     clk      single clock, rising edge
//     reset_n  asynchronous active-low reset
//     seq      branch_pc_sequencer_if.slave (see interface header)
//
//   States
//     S_IDLE    | waiting for start; disp latched on accept
//     S_STROBE  | CONin register is set at the end of this cycle
//     S_SETTLE  | CON FF output settling, SETTLE cycles
//     S_RESOLVE | BranchIn sampled, PC/counters/done updated at cycle end
//
//   Timing (start sampled at edge N): CONin high after N+1, done/taken/PC
//   update after N+2+SETTLE.
// ---------------------------------------------------------------------------
module branch_pc_sequencer #(
    parameter int PC_W   = 32,
    parameter int DISP_W = 19,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    branch_pc_sequencer_if.slave  seq
);

    // Settle down-counter holds SETTLE-1 .. 0.
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STROBE  = 2'd1,
        S_SETTLE  = 2'd2,
        S_RESOLVE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [PC_W-1:0]   disp_q, disp_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              conin_q;
    logic              done_q;
    logic              taken_q;
    logic [CNT_W-1:0]  taken_cnt_q;
    logic [CNT_W-1:0]  nt_cnt_q;

    logic              resolve;
    logic              branch_taken;
    logic [PC_W-1:0]   disp_sext;

    // IR bits above the displacement field carry opcode/register fields that
    // are not ours to decode.
    logic              unused_ir_hi;
    assign unused_ir_hi = ^seq.IR[PC_W-1:DISP_W];

    assign disp_sext = {{(PC_W-DISP_W){seq.IR[DISP_W-1]}}, seq.IR[DISP_W-1:0]};

    // -----------------------------------------------------------------------
    // Next-state, datapath selects
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        disp_d       = disp_q;
        resolve      = 1'b0;
        branch_taken = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (seq.start) begin
                    disp_d  = disp_sext;
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                settle_d = SET_LOAD;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = S_RESOLVE;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            S_RESOLVE: begin
                resolve      = 1'b1;
                branch_taken = seq.BranchIn;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A PC load while a branch is in flight abandons the branch: the
        // control unit has redirected the program, so no outcome is reported.
        if (seq.PCload && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            resolve      = 1'b0;
            branch_taken = 1'b0;
        end
    end

    // PCload beats a taken branch, which beats a plain increment.
    always_comb begin
        pc_d = pc_q;
        if (seq.PCload) begin
            pc_d = seq.Bus;
        end else if (branch_taken) begin
            pc_d = pc_q + disp_q;
        end else if (seq.IncPC) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
            disp_q   <= '0;
            pc_q     <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            disp_q   <= disp_d;
            pc_q     <= pc_d;
        end
    end

    // CONin is a flop output so the CON FF sees a single clean edge; an abort
    // in STROBE keeps it from ever rising.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conin_q <= 1'b0;
        end else begin
            conin_q <= (state_q == S_STROBE) && !seq.PCload;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q  <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            done_q <= resolve;
            if (resolve) begin
                taken_q <= seq.BranchIn;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            taken_cnt_q <= '0;
            nt_cnt_q    <= '0;
        end else if (resolve) begin
            if (seq.BranchIn) begin
                if (taken_cnt_q != CNT_MAX) begin
                    taken_cnt_q <= taken_cnt_q + CNT_W'(1);
                end
            end else begin
                if (nt_cnt_q != CNT_MAX) begin
                    nt_cnt_q <= nt_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign seq.CONin     = conin_q;
    assign seq.PC        = pc_q;
    assign seq.busy      = (state_q != S_IDLE);
    assign seq.done      = done_q;
    assign seq.taken     = taken_q;
    assign seq.taken_cnt = taken_cnt_q;
    assign seq.nt_cnt    = nt_cnt_q;

endmodule
